satd_diff_stream: RTL
=====================

// Module: satd_diff_stream
// PURPOSE
//  Parametrised row-sequenced difference front-end for the SATD datapath.
//  - Accepts one whole ORG/CUR block through a valid/ready handshake.
//  - Emits one row of signed differences (org - cur) per cycle under output
//    backpressure; supports 4x4 and 8x8 blocks at run time.
//  - Sits between the block fetch logic and the Hadamard transform stage.
// PARAMETERS
//  MAX_N      8  maximum block side (power of 2, >=4); rows = cols = MAX_N
//  BIT_DEPTH  8  sample width in bits; DIFF_W = BIT_DEPTH+1
// PORTS
//  clk        in   1                      clock, rising edge
//  rst        in   1                      synchronous, active-high reset
//  in_valid   in   1                      block offered
//  in_ready   out  1                      block accepted when in_valid&in_ready
//  blk_size   in   1                      0=4x4, 1=8x8 (sampled on accept)
//  org_blk    in   MAX_N*MAX_N*BIT_DEPTH  original samples; (r,c) at [((r*MAX_N)+c)*BIT_DEPTH +: BIT_DEPTH]
//  cur_blk    in   MAX_N*MAX_N*BIT_DEPTH  candidate samples, same packing
//  out_valid  out  1                      out_row valid
//  out_ready  in   1                      consumer takes row when out_valid&out_ready
//  out_row    out  MAX_N*DIFF_W           lane c at [c*DIFF_W +: DIFF_W], signed
//  out_row_idx out $clog2(MAX_N)          row index of out_row
//  out_last   out  1                      out_row is final row of block
//  busy       out  1                      high in RUN
//  sad        out  BIT_DEPTH+2*$clog2(MAX_N)  block SAD (see CONFIGURATION)
//  sad_valid  out  1                      one-cycle strobe, sad valid
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_row=0, out_row_idx=0,
//    out_last=0, busy=0, sad=0, sad_valid=0; captured block discarded.
//  - FSM IDLE: in_ready=1; on accept, register org/cur/blk_size, n=4 or 8,
//    row ptr=0, go RUN.
//  - FSM RUN: in_ready=0. Output register loads row ptr when
//    !out_valid | out_ready, and ptr < n. Ptr then increments.
//  - Latency: accept at edge t -> row 0 valid after edge t+1; with out_ready
//    held high, one row per cycle, rows 0..n-1 in order.
//  - Backpressure: out_valid&!out_ready holds out_row/idx/last stable.
//  - out_last=1 only with idx n-1. When that handshake occurs: out_valid=0 at
//    next edge, FSM returns to IDLE, in_ready=1 from that cycle.
//  - No overlap: a new block is not accepted in the last-row handshake cycle.
//  - Arithmetic: diff = {1'b0,org} - {1'b0,cur} in DIFF_W two's complement.
//    Range is -(2^BD-1)..+(2^BD-1); no saturation is needed.
//  - 4x4 mode: lanes 4..MAX_N-1 output 0. Only samples r<4, c<4 are used,
//    with MAX_N stride; other inputs are ignored.
//  - in_valid while in RUN is ignored; the producer holds it (standard handshake).
//  - rst mid-block: all outputs take reset values at that edge; no partial
//    row or SAD strobe is emitted.
// CONFIGURATION
//  SATD_DIFF_SAD_EN defined:
//  - sad accumulates sum|diff| over valid lanes of each row at handshake.
//  - Accumulator is cleared on block accept.
//  - sad_valid pulses 1 cycle after the last-row handshake; sad holds until
//    the next accept.
//  SATD_DIFF_SAD_EN undefined: sad and sad_valid tied 0; no accumulator.
// STRUCTURE
//  - satd_pkg holds: DIFF_W function, SAD_W function, blk_size_e {BLK_4X4,
//    BLK_8X8}, state_e {IDLE, RUN}.
//  - Sub-module satd_row_diff: MAX_N-lane combinational subtractor. Inputs are
//    one org row, one cur row and a lane mask; output is the packed diff row.
//    Instantiated once, with the row selected by ptr.
// TESTING
//  1 Reset: assert rst 2 cycles -> in_ready=1, out_valid=0, sad=0,
//    sad_valid=0.
//  2 8x8, org=all 200, cur=all 50, out_ready=1:
//    - rows 0..7 on 8 consecutive cycles, every lane +150;
//    - out_last only on idx 7;
//    - sad=9600 with SAD_EN.
//  3 4x4, org(r,c)=0, cur(r,c)=255:
//    - 4 rows, lanes 0..3 = -255, lanes 4..7 = 0;
//    - out_last on idx 3; sad=4080.
//  4 Backpressure: 8x8 ramp with out_ready low on rows 2 and 5 for 3 cycles
//    -> row data/idx stable while stalled, no row lost or duplicated.
//  5 rst asserted after row 3 handshake -> out_valid=0 next cycle, no
//    sad_valid. A new block is then accepted and emitted from row 0.
//  6 Back-to-back blocks with in_valid held high -> second accept one cycle
//    after first out_last handshake; sad_valid strobes once per block.

Source files
------------

// File: rtl/satd_diff_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : satd_pkg
//  Purpose  : Shared types and width helpers for the SATD difference front-end
//  Revision : 1.0  initial release
// ============================================================================
package satd_pkg;

    // A difference of two unsigned samples needs one extra bit for the sign.
    function automatic int diff_w(input int bit_depth);
        return bit_depth + 1;
    endfunction

    // Sum of |diff| over a MAX_N x MAX_N block: magnitude bits plus log2(area).
    function automatic int sad_w(input int bit_depth, input int max_n);
        return bit_depth + 2 * $clog2(max_n);
    endfunction

    typedef enum logic {
        BLK_4X4 = 1'b0,
        BLK_8X8 = 1'b1
    } blk_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/satd_row_diff.sv
`default_nettype none
// ============================================================================
//  Module   : satd_row_diff
//  Purpose  : MAX_N-lane combinational subtractor producing one signed row of
//             (org - cur); masked-off lanes are forced to zero.
//  Revision : 1.0  initial release
// ============================================================================
module satd_row_diff
    import satd_pkg::*;
#(
    parameter  int MAX_N     = 8,
    parameter  int BIT_DEPTH = 8,
    localparam int DIFF_W    = diff_w(BIT_DEPTH)
) (
    input  logic [MAX_N*BIT_DEPTH-1:0] org_row_i,
    input  logic [MAX_N*BIT_DEPTH-1:0] cur_row_i,
    input  logic [MAX_N-1:0]           lane_mask_i,
    output logic [MAX_N*DIFF_W-1:0]    diff_row_o
);

    for (genvar c = 0; c < MAX_N; c++) begin : g_lane
        logic [DIFF_W-1:0] w_diff;

        // Zero-extend both samples so the DIFF_W-bit result is exact two's complement.
        assign w_diff = {1'b0, org_row_i[c*BIT_DEPTH +: BIT_DEPTH]}
                      - {1'b0, cur_row_i[c*BIT_DEPTH +: BIT_DEPTH]};
        assign diff_row_o[c*DIFF_W +: DIFF_W] = lane_mask_i[c] ? w_diff : '0;
    end

endmodule
`default_nettype wire

// File: rtl/satd_diff_stream.sv
`default_nettype none
// ============================================================================
//  Module   : satd_diff_stream
//  Purpose  : Accepts one ORG/CUR block and streams one row of signed
//             differences per cycle under output backpressure (4x4 or 8x8).
//  Options  : SATD_DIFF_SAD_EN - adds a per-block sum of |diff| with a
//             one-cycle valid strobe; when undefined sad/sad_valid are 0.
//  Revision : 1.0  initial release
// ============================================================================
module satd_diff_stream
    import satd_pkg::*;
#(
    parameter  int MAX_N     = 8,
    parameter  int BIT_DEPTH = 8,
    localparam int DIFF_W    = diff_w(BIT_DEPTH),
    localparam int SAD_W     = sad_w(BIT_DEPTH, MAX_N),
    localparam int IDX_W     = $clog2(MAX_N)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             blk_size,
    input  logic [MAX_N*MAX_N*BIT_DEPTH-1:0] org_blk,
    input  logic [MAX_N*MAX_N*BIT_DEPTH-1:0] cur_blk,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MAX_N*DIFF_W-1:0]          out_row,
    output logic [IDX_W-1:0]                 out_row_idx,
    output logic                             out_last,
    output logic                             busy,
    output logic [SAD_W-1:0]                 sad,
    output logic                             sad_valid
);

    localparam int BLK_BITS = MAX_N * MAX_N * BIT_DEPTH;
    localparam int ROW_BITS = MAX_N * BIT_DEPTH;
    localparam int ROW_W    = MAX_N * DIFF_W;
    // Pointer needs one extra bit so it can reach n (= "all rows issued").
    localparam int PTR_W    = IDX_W + 1;

    localparam logic [PTR_W-1:0] N_SMALL = PTR_W'(4);
    localparam logic [PTR_W-1:0] N_LARGE = (MAX_N >= 8) ? PTR_W'(8) : PTR_W'(4);

    state_e              state_q, state_d;
    logic [BLK_BITS-1:0] org_q, cur_q;
    blk_size_e           blk_q;
    logic [PTR_W-1:0]    ptr_q, n_q;
    logic [ROW_W-1:0]    row_q;
    logic [IDX_W-1:0]    idx_q;
    logic                last_q, valid_q;

    logic                w_accept, w_hs, w_last_hs, w_load;
    logic [IDX_W-1:0]    w_row_sel;
    logic [ROW_BITS-1:0] w_org_row, w_cur_row;
    logic [MAX_N-1:0]    w_lane_mask;
    logic [ROW_W-1:0]    w_diff_row;

    assign w_accept  = (state_q == IDLE) && in_valid;
    assign w_hs      = valid_q && out_ready;
    assign w_last_hs = w_hs && last_q;
    // Refill the output register when it is empty or being drained this cycle.
    assign w_load    = (state_q == RUN) && (!valid_q || out_ready) && (ptr_q < n_q);

    // Rows are contiguous in the packed block, so a row is one part-select.
    assign w_row_sel = ptr_q[IDX_W-1:0];
    assign w_org_row = org_q[int'(w_row_sel) * ROW_BITS +: ROW_BITS];
    assign w_cur_row = cur_q[int'(w_row_sel) * ROW_BITS +: ROW_BITS];

    // Lanes 0..3 always active; lanes 4..7 only for an 8x8 block.
    always_comb begin
        w_lane_mask = '0;
        for (int c = 0; c < MAX_N; c++) begin
            w_lane_mask[c] = (c < 4) || ((blk_q == BLK_8X8) && (c < 8));
        end
    end

    satd_row_diff #(
        .MAX_N     (MAX_N),
        .BIT_DEPTH (BIT_DEPTH)
    ) u_row_diff (
        .org_row_i   (w_org_row),
        .cur_row_i   (w_cur_row),
        .lane_mask_i (w_lane_mask),
        .diff_row_o  (w_diff_row)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> RUN on accept, RUN -> IDLE on the last-row handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (w_last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Captured block; never emitted unless a RUN follows, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            org_q <= org_blk;
            cur_q <= cur_blk;
        end
    end

    // Row sequencer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q   <= BLK_4X4;
            n_q     <= N_SMALL;
            ptr_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (w_accept) begin
                blk_q <= blk_size_e'(blk_size);
                n_q   <= (blk_size == BLK_8X8) ? N_LARGE : N_SMALL;
                ptr_q <= '0;
            end
            if (w_load) begin
                row_q   <= w_diff_row;
                idx_q   <= w_row_sel;
                last_q  <= (ptr_q == n_q - 1'b1);
                valid_q <= 1'b1;
                ptr_q   <= ptr_q + 1'b1;
            end else if (w_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

`ifdef SATD_DIFF_SAD_EN
    logic [SAD_W-1:0]  sad_q;
    logic              sad_valid_q;
    logic [SAD_W-1:0]  w_row_abs;
    logic [DIFF_W-1:0] w_lane, w_mag;

    // Sum of magnitudes of the row currently presented; masked lanes are 0.
    always_comb begin
        w_row_abs = '0;
        w_lane    = '0;
        w_mag     = '0;
        for (int c = 0; c < MAX_N; c++) begin
            w_lane    = row_q[c*DIFF_W +: DIFF_W];
            w_mag     = w_lane[DIFF_W-1] ? (~w_lane + 1'b1) : w_lane;
            w_row_abs = w_row_abs + SAD_W'(w_mag);
        end
    end

    // Accumulate at each row handshake; strobe after the final row.
    always_ff @(posedge clk) begin
        if (rst) begin
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
        end else begin
            sad_valid_q <= w_last_hs;
            if (w_accept) begin
                sad_q <= '0;
            end else if (w_hs) begin
                sad_q <= sad_q + w_row_abs;
            end
        end
    end

    assign sad       = sad_q;
    assign sad_valid = sad_valid_q;
`else
    assign sad       = '0;
    assign sad_valid = 1'b0;
`endif

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign out_valid   = valid_q;
    assign out_row     = row_q;
    assign out_row_idx = idx_q;
    assign out_last    = last_q;

endmodule
`default_nettype wire
